// File: rtl/bias_bank_adder.sv
`default_nettype none
// ============================================================================
// Module   : bias_bank_adder
// Purpose  : Run-time loadable bias banks added to adder-tree output vectors
//            via a two-stage valid/ready pipeline. Optional macro BIAS_SAT_EN
//            selects saturating adds with per-channel flags instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================
module bias_bank_adder #(
    parameter int N_adder_tree = 16,
    parameter int W            = 18,
    parameter int N_BANKS      = 8,
    parameter int BW           = $clog2(N_BANKS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_start,
    input  logic [BW-1:0]             load_bank,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [W-1:0]              load_data,
    output logic                      load_done,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BW-1:0]             in_bank,
    input  logic [N_adder_tree*W-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_adder_tree*W-1:0] out_data,
    output logic [N_adder_tree-1:0]   sat_flag
);

    localparam int            CW     = (N_adder_tree > 1) ? $clog2(N_adder_tree) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(N_adder_tree - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        w_start;
    logic                        w_wr;
    logic                        w_last;
    logic [BW-1:0]               r_lbank;
    logic [CW-1:0]               r_wcnt;
    logic                        r_load_done;
    logic [W-1:0]                r_bank [N_BANKS][N_adder_tree];

    logic                        w_s1_free;
    logic                        w_s2_free;
    logic                        w_accept;
    logic [N_adder_tree*W-1:0]   w_bias_rd;
    logic                        r_s1_v;
    logic [N_adder_tree*W-1:0]   r_s1_data;
    logic [N_adder_tree*W-1:0]   r_s1_bias;
    logic [N_adder_tree*W-1:0]   w_res;
    logic [N_adder_tree-1:0]     w_sat;
    logic                        r_s2_v;
    logic [N_adder_tree*W-1:0]   r_s2_data;
    logic [N_adder_tree-1:0]     r_s2_sat;

    // ------------------------------------------------------------------ load FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        load_ready  = 1'b0;
        w_start     = 1'b0;
        w_wr        = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_start) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_ready = 1'b1;
                w_wr       = load_valid;
                w_last     = load_valid && (r_wcnt == C_LAST);
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lbank     <= '0;
            r_wcnt      <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= w_last;
            if (w_start) begin
                r_lbank <= load_bank;
                r_wcnt  <= '0;
            end else if (w_wr) begin
                r_wcnt  <= w_last ? '0 : r_wcnt + CW'(1);
            end
        end
    end

    // Reset clears every bank so a partially loaded bank never leaks old words.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < N_BANKS; b++) begin
                for (int c = 0; c < N_adder_tree; c++) begin
                    r_bank[b][c] <= '0;
                end
            end
        end else if (w_wr) begin
            r_bank[r_lbank][r_wcnt] <= load_data;
        end
    end

    assign load_done = r_load_done;

    // ------------------------------------------------------------ apply pipeline
    assign w_s2_free = !r_s2_v || out_ready;
    assign w_s1_free = !r_s1_v || w_s2_free;
    assign in_ready  = w_s1_free && (r_state == ST_IDLE);
    assign w_accept  = in_valid && in_ready;

    for (genvar i = 0; i < N_adder_tree; i++) begin : g_rd
        assign w_bias_rd[W*i +: W] = r_bank[in_bank][i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_data <= '0;
            r_s1_bias <= '0;
        end else if (w_s1_free) begin
            r_s1_v <= w_accept;
            if (w_accept) begin
                r_s1_data <= in_data;
                r_s1_bias <= w_bias_rd;
            end
        end
    end

    for (genvar i = 0; i < N_adder_tree; i++) begin : g_ch
        logic [W-1:0] w_a;
        logic [W-1:0] w_b;
        assign w_a = r_s1_data[W*i +: W];
        assign w_b = r_s1_bias[W*i +: W];
`ifdef BIAS_SAT_EN
        logic [W:0] w_sum;
        logic       w_ovf;
        assign w_sum = {w_a[W-1], w_a} + {w_b[W-1], w_b};
        // Sign bits disagree only when the W+1-bit sum left the W-bit range.
        assign w_ovf = w_sum[W] ^ w_sum[W-1];
        assign w_res[W*i +: W] = !w_ovf     ? w_sum[W-1:0] :
                                 w_sum[W]   ? {1'b1, {(W-1){1'b0}}} :
                                              {1'b0, {(W-1){1'b1}}};
        assign w_sat[i] = w_ovf;
`else
        assign w_res[W*i +: W] = w_a + w_b;
        assign w_sat[i]        = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_v    <= 1'b0;
            r_s2_data <= '0;
            r_s2_sat  <= '0;
        end else if (w_s2_free) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_data <= w_res;
                r_s2_sat  <= w_sat;
            end
        end
    end

    assign out_valid = r_s2_v;
    assign out_data  = r_s2_data;
    assign sat_flag  = r_s2_sat;

endmodule
`default_nettype wire
